// File: rtl/fwd_layer_mac.sv
// Forward pass of one dense layer: y[o] = sat(relu((sum_i x[i]*w[o*N_IN+i]) >>> SHIFT)).
// One MAC per enabled cycle, one write-back cycle per neuron, then a one-shot done pulse.
module fwd_layer_mac #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 20,
    parameter int SHIFT = 4,
    parameter int AW    = $clog2(N_IN * N_OUT)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     pass_i,
    input  logic                     wr_en_i,
    input  logic                     wr_sel_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [DW-1:0]            wr_data_i,
    input  logic [$clog2(N_OUT)-1:0] rd_addr_i,
    output logic [DW-1:0]            y_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [1:0]               dbg_state_o
);

    localparam int IW = $clog2(N_IN);
    localparam int OW = $clog2(N_OUT);
    localparam logic signed [ACC_W-1:0] L_YMAX = ACC_W'((1 << (DW - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_WB   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                   r_state;
    logic [DW-1:0]            r_x [N_IN];
    logic [DW-1:0]            r_w [N_IN*N_OUT];
    logic [DW-1:0]            r_y [N_OUT];
    logic signed [ACC_W-1:0]  r_acc;
    logic [IW-1:0]            r_i;
    logic [OW-1:0]            r_o;
    logic                     r_busy;
    logic                     r_done;

    logic [AW-1:0]            w_widx;
    logic signed [2*DW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_shr;
    logic [DW-1:0]            w_act;

    always_comb begin
        w_widx     = AW'(int'(r_o) * N_IN + int'(r_i));
        w_prod     = $signed(r_x[r_i]) * $signed(r_w[w_widx]);
        w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
        w_shr      = r_acc >>> SHIFT;
        // ReLU clamps negatives to zero; positive overflow saturates to the DW-bit max.
        if (w_shr[ACC_W-1])
            w_act = '0;
        else if (w_shr > L_YMAX)
            w_act = L_YMAX[DW-1:0];
        else
            w_act = w_shr[DW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_i     <= '0;
            r_o     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < N_IN; k++)        r_x[k] <= '0;
            for (int k = 0; k < N_IN*N_OUT; k++)  r_w[k] <= '0;
            for (int k = 0; k < N_OUT; k++)       r_y[k] <= '0;
        end else if (en_i) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_en_i) begin
                        if (!wr_sel_i && int'(wr_addr_i) < N_IN)
                            r_x[wr_addr_i[IW-1:0]] <= wr_data_i;
                        else if (wr_sel_i && int'(wr_addr_i) < N_IN * N_OUT)
                            r_w[wr_addr_i] <= wr_data_i;
                    end
                    if (pass_i) begin
                        r_state <= S_MAC;
                        r_o     <= '0;
                        r_i     <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_i   <= r_i + IW'(1);
                    if (r_i == IW'(N_IN - 1))
                        r_state <= S_WB;
                end
                S_WB: begin
                    r_y[r_o] <= w_act;
                    r_acc    <= '0;
                    r_i      <= '0;
                    if (r_o == OW'(N_OUT - 1)) begin
                        r_state <= S_HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_o     <= r_o + OW'(1);
                        r_state <= S_MAC;
                    end
                end
                S_HOLD: begin
                    // Wait for the request level to drop so a held pass_i runs only once.
                    if (!pass_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign y_o         = r_y[rd_addr_i];
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_fwd_layer_mac.sv
// Directed bench for fwd_layer_mac: hand-computed activations, pass timing,
// held request, enable stalls, dropped writes while busy and mid-pass reset.
module tb_fwd_layer_mac;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       en_i = 1'b1;
    logic       pass_i = 1'b0;
    logic       wr_en_i = 1'b0;
    logic       wr_sel_i = 1'b0;
    logic [3:0] wr_addr_i = '0;
    logic [7:0] wr_data_i = '0;
    logic [1:0] rd_addr_i = '0;
    logic [7:0] y_o;
    logic       busy_o;
    logic       done_o;
    logic [1:0] dbg_state_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    fwd_layer_mac dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .pass_i      (pass_i),
        .wr_en_i     (wr_en_i),
        .wr_sel_i    (wr_sel_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .rd_addr_i   (rd_addr_i),
        .y_o         (y_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        wr_en_i   = 1'b1;
        wr_sel_i  = sel;
        wr_addr_i = addr;
        wr_data_i = data;
        step();
        wr_en_i = 1'b0;
    endtask

    task automatic wr_row(input int row, input int a, input int b, input int c, input int d);
        wr(1'b1, 4'(row * 4 + 0), 8'(a));
        wr(1'b1, 4'(row * 4 + 1), 8'(b));
        wr(1'b1, 4'(row * 4 + 2), 8'(c));
        wr(1'b1, 4'(row * 4 + 3), 8'(d));
    endtask

    task automatic wr_x(input int a, input int b, input int c, input int d);
        wr(1'b0, 4'd0, 8'(a));
        wr(1'b0, 4'd1, 8'(b));
        wr(1'b0, 4'd2, 8'(c));
        wr(1'b0, 4'd3, 8'(d));
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];

    task automatic check_y(input string tag);
        for (int k = 0; k < 4; k++) begin
            rd_addr_i = 2'(k);
            #1;
            check_eq($sformatf("%s_y%0d", tag, k), 32'(y_o), 32'(exp_q.pop_front()));
        end
    endtask

    // Starts a pass on the next edge (sample 1 follows it) and observes 70 samples.
    task automatic run_pass(input string tag, input int hold_cycles, input bit en_toggle,
                            input int wr_cycle, input int exp_done_cyc, input int exp_busy);
        int  done_cyc;
        int  busy_cnt;
        int  rises;
        bit  prev_done;
        done_cyc  = 0;
        busy_cnt  = 0;
        rises     = 0;
        prev_done = 1'b0;
        pass_i = 1'b1;
        en_i   = 1'b1;
        step();
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (done_o && !prev_done) begin
                rises++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            prev_done = done_o;
            if (busy_o) busy_cnt++;
            pass_i    = (cyc < hold_cycles);
            en_i      = !(en_toggle && (cyc % 2 == 1));
            wr_en_i   = (cyc == wr_cycle);
            wr_sel_i  = 1'b0;
            wr_addr_i = 4'd0;
            wr_data_i = 8'd99;
            step();
        end
        pass_i  = 1'b0;
        en_i    = 1'b1;
        wr_en_i = 1'b0;
        check_eq({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
        check_eq({tag, "_done_pulses"}, 32'(rises), 32'd1);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check_eq({tag, "_state_idle"}, 32'(dbg_state_o), 32'd0);
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        exp_q.push_back(8'(a));
        exp_q.push_back(8'(b));
        exp_q.push_back(8'(c));
        exp_q.push_back(8'(d));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b0;
        repeat (2) step();
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_state", 32'(dbg_state_o), 32'd0);
        push4(0, 0, 0, 0);
        check_y("rst");
        rst_i = 1'b1;
        step();

        // Basic pass: 16*(1+2+3+4) = 160, >>>4 = 10.
        wr_x(1, 2, 3, 4);
        wr_row(0, 16, 16, 16, 16);
        wr(1'b0, 4'd4, 8'd50);
        run_pass("basic", 1, 1'b0, 0, 21, 20);
        push4(10, 0, 0, 0);
        check_y("basic");

        // Row 1 negative -> ReLU 0; row 3: 5-6+21+4 = 24 -> 1.
        wr_row(1, -16, -16, -16, -16);
        wr_row(3, 5, -3, 7, 1);
        run_pass("relu", 1, 1'b0, 0, 21, 20);
        push4(10, 0, 0, 1);
        check_y("relu");

        // Held request runs once; a later pulse runs again.
        run_pass("held", 40, 1'b0, 0, 21, 20);
        push4(10, 0, 0, 1);
        check_y("held");
        run_pass("again", 1, 1'b0, 0, 21, 20);
        push4(10, 0, 0, 1);
        check_y("again");

        // Enable toggled every cycle doubles latency.
        run_pass("stall", 1, 1'b1, 0, 41, 40);
        push4(10, 0, 0, 1);
        check_y("stall");

        // x[0] = 99 written at cycle 5 must be dropped.
        run_pass("busywr", 1, 1'b0, 5, 21, 20);
        push4(10, 0, 0, 1);
        check_y("busywr");

        // Saturation: x=127; 8128>>>4=508 -> 127; 64516>>>4=4032 -> 127; 254>>>4=15.
        wr_x(127, 127, 127, 127);
        wr_row(2, 127, 127, 127, 127);
        wr_row(3, 1, -1, 2, 0);
        run_pass("sat", 1, 1'b0, 0, 21, 20);
        push4(127, 0, 127, 15);
        check_y("sat");

        // Reset mid-pass at cycle 8.
        pass_i = 1'b1;
        step();
        pass_i = 1'b0;
        repeat (7) step();
        check_eq("mid_busy_before", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check_eq("mid_busy", 32'(busy_o), 32'd0);
        check_eq("mid_done", 32'(done_o), 32'd0);
        check_eq("mid_state", 32'(dbg_state_o), 32'd0);
        push4(0, 0, 0, 0);
        check_y("mid");
        pass_i = 1'b1;
        step();
        rst_i = 1'b1;
        // Pass already high at release; x and w were cleared so all outputs stay 0.
        run_pass("postrst", 1, 1'b0, 0, 21, 20);
        push4(0, 0, 0, 0);
        check_y("postrst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fwd_layer_mac.md
# fwd_layer_mac

Forward-pass datapath for one dense layer of the on-chip training network; sits directly downstream of the training state machine and consumes its `f0_pass` strobe. On a pass request it multiplies a stored input vector by a stored weight matrix neuron by neuron, applies shift, ReLU and saturation, and writes the activations into an output register file. When the pass completes it emits a one-cycle `done_o`, which feeds the state machine's `f0_end_i` input.

## Interface
Parameters:
- `N_IN`, 4: inputs per neuron.
- `N_OUT`, 4: neurons (outputs).
- `DW`, 8: signed width of inputs, weights and activations.
- `ACC_W`, 20: signed accumulator width; must be ≥ 2·DW + clog2(N_IN).
- `SHIFT`, 4: arithmetic right shift applied to the accumulator before activation.
- `AW`, clog2(N_IN·N_OUT): write/read address width.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset. Asynchronous and active-low.
- `en_i`  in  1  global enable. When low, every register holds its value, including the register files.
- `pass_i`  in  1  pass request level, driven by `f0_pass_o`.
- `wr_en_i`  in  1  register-file write strobe.
- `wr_sel_i`  in  1  write target: 0 = input x[addr], 1 = weight w[addr].
- `wr_addr_i`  in  AW  write address. Weight index is o·N_IN + i.
- `wr_data_i`  in  DW  signed write data.
- `rd_addr_i`  in  clog2(N_OUT)  activation read address.
- `y_o`  out  DW  activation y[rd_addr_i]. Combinational read.
- `busy_o`  out  1  high in MAC and WB.
- `done_o`  out  1  one-cycle pass-complete pulse.

## Operation
- Reset values: all register-file entries (x, w, y), the accumulator and the counters are 0; state is IDLE; `busy_o` = 0; `done_o` = 0.
- The FSM has four states: IDLE, MAC, WB, HOLD. All transitions require `en_i` = 1.
- IDLE:
  - `pass_i` = 1 → MAC, with o = 0, i = 0 and acc = 0.
  - Writes are accepted only in IDLE.
  - An out-of-range write address is ignored.
- MAC:
  - Each cycle, acc += sext(x[i]) · sext(w[o·N_IN+i]), and i increments.
  - When i = N_IN−1, the last product is added, then → WB.
- WB:
  - Compute r = acc >>> SHIFT (arithmetic).
  - y[o] = 0 if r < 0; 2^(DW−1)−1 if r > 2^(DW−1)−1; otherwise r[DW−1:0].
  - Then acc = 0 and i = 0.
  - If o = N_OUT−1 → HOLD, with `done_o` = 1 in the first HOLD cycle. Otherwise o++ → MAC.
- HOLD:
  - Stays until `pass_i` = 0, then → IDLE. This prevents a second pass from a level that is still high.
  - `done_o` is high for exactly one cycle on HOLD entry.
- `pass_i` falling during MAC or WB does not abort the pass; the pass completes.
- Writes while `busy_o` = 1 or in HOLD are dropped; no register changes.
- Reads of y are permitted at any time. During a pass, y[o] for already-completed neurons shows the new value, and the others show the old value.
- The accumulator never wraps, given the ACC_W constraint.

## Timing
- Start: `pass_i` is sampled high in IDLE at edge 0. MAC runs on edges 1..N_IN, WB on edge N_IN+1, for each neuron.
- Pass length is N_OUT·(N_IN+1) enabled cycles; 20 with the default parameters.
- `done_o` rises one cycle after the final WB edge: cycle 21 relative to the start edge with the defaults.
- `busy_o` is high for exactly N_OUT·(N_IN+1) enabled cycles.
- `en_i` low stretches all latencies one-for-one. Results are identical to an uninterrupted run.
- Asynchronous reset mid-pass immediately returns to IDLE, clears y, x, w and acc, and drops `busy_o` and `done_o`.
- A `pass_i` that is already high when reset releases starts a pass on the first enabled edge.

## Test plan
- Basic pass: x = [1,2,3,4]; row 0 = [16,16,16,16]; other rows 0; pulse `pass_i` → y0 = 160>>>4 = 10, y1..y3 = 0, `done_o` one cycle at cycle 21.
- ReLU and saturation: row 1 = [−16,−16,−16,−16] → y1 = 0. Row 2 all 127 with x all 127 → acc = 64516 → y2 = 127.
- Held request: `pass_i` held high for 40 cycles → exactly one `done_o`. A second `pass_i` pulse afterward → second pass, same results.
- `en_i` toggled 50% during the pass → `done_o` at cycle 41, y values identical to the basic run.
- Write during busy: `wr_en_i` with x[0] = 99 at cycle 5 → ignored. A post-pass read of x-dependent results matches the original x.
- Reset mid-pass: assert `rst_i` = 0 at cycle 8 → `busy_o` = 0 and all `y_o` = 0 immediately, FSM in IDLE, no `done_o`.
